// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, instruction-memory request/response handling and
// IF/ID pipeline register with a one-entry skid buffer for decode stalls.
// Redirect sources: execute (branch/JR/JALR) and decode (J/JAL displacement).
module fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        jump_disp_en,
  input  logic        ex_redirect,
  input  logic [15:0] ex_target,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc2,
  output logic        if_id_valid,
  output logic        halted
);

  localparam int unsigned XLEN  = 16;
  localparam int unsigned OPW   = 5;
  localparam int unsigned DISPW = 11;
  localparam int unsigned SEXTW = XLEN - DISPW;

  localparam logic [OPW-1:0]  OP_HALT = 5'b00000;
  localparam logic [XLEN-1:0] PC_STEP = 16'd2;

  // Instruction word paired with its return address (PC+2)
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc2;
  } slot_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // State registers
  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_pc;
  slot_t           r_ifid;
  logic            r_ifid_valid;
  slot_t           r_skid;
  logic            r_skid_valid;

  // Next-state values
  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_pend_pc_nxt;
  slot_t           w_ifid_nxt;
  logic            w_ifid_valid_nxt;
  slot_t           w_skid_nxt;
  logic            w_skid_valid_nxt;

  // Datapath helpers
  logic            w_req;
  logic            w_accept;
  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_disp_sext;
  logic [XLEN-1:0] w_dec_target;
  logic            w_dec_redir;
  logic            w_redir;
  logic [XLEN-1:0] w_target;
  logic            w_is_halt;
  slot_t           w_fetched;

  // Request is live in FETCH with an empty skid, and always while draining;
  // gated by rst_n so nothing is requested while reset is asserted.
  assign w_req = rst_n & (((r_state == ST_FETCH) & ~r_skid_valid) |
                          (r_state == ST_DRAIN));
  assign w_accept = w_req & imem_rdy;

  assign w_pc_inc  = r_pc + PC_STEP;
  assign w_is_halt = (imem_rdata[XLEN-1 -: OPW] == OP_HALT);
  assign w_fetched = '{instr: imem_rdata, pc2: w_pc_inc};

  // Decode-side displacement jump; execute redirect always takes priority
  assign w_disp_sext  = {{SEXTW{r_ifid.instr[DISPW-1]}}, r_ifid.instr[DISPW-1:0]};
  assign w_dec_target = r_ifid.pc2 + w_disp_sext;
  assign w_dec_redir  = r_ifid_valid & jump_disp_en & ~stall & ~ex_redirect;
  assign w_redir      = ex_redirect | w_dec_redir;
  assign w_target     = ex_redirect ? ex_target : w_dec_target;

  // Next-state and datapath update for PC, IF/ID, skid and drain target
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pend_pc_nxt    = r_pend_pc;
    w_ifid_nxt       = r_ifid;
    w_ifid_valid_nxt = r_ifid_valid;
    w_skid_nxt       = r_skid;
    w_skid_valid_nxt = r_skid_valid;

    if (w_redir) begin
      // Flush everything younger than the redirect; stall is irrelevant
      w_ifid_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
      if (w_req && !imem_rdy) begin
        // A request is in flight: remember where to go once it retires
        w_pend_pc_nxt = w_target;
        w_state_nxt   = ST_DRAIN;
      end else begin
        w_pc_nxt    = w_target;
        w_state_nxt = ST_FETCH;
      end
    end else begin
      if (!stall) begin
        if (r_skid_valid) begin
          w_ifid_nxt       = r_skid;
          w_ifid_valid_nxt = 1'b1;
          w_skid_valid_nxt = 1'b0;
        end else begin
          w_ifid_valid_nxt = 1'b0;
        end
      end

      case (r_state)
        ST_FETCH: begin
          if (w_accept) begin
            w_pc_nxt = w_pc_inc;
            if (!stall && !r_skid_valid) begin
              w_ifid_nxt       = w_fetched;
              w_ifid_valid_nxt = 1'b1;
            end else begin
              w_skid_nxt       = w_fetched;
              w_skid_valid_nxt = 1'b1;
            end
            if (w_is_halt) begin
              w_state_nxt = ST_HALT;
            end
          end
        end
        ST_DRAIN: begin
          // Stale response retires; its data is dropped
          if (imem_rdy) begin
            w_pc_nxt    = r_pend_pc;
            w_state_nxt = ST_FETCH;
          end
        end
        default: begin
          // HALT: hold until a redirect restarts fetch
        end
      endcase
    end
  end

  // State register; an in-flight request is simply abandoned on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FETCH;
      r_pc         <= '0;
      r_pend_pc    <= '0;
      r_ifid       <= '0;
      r_ifid_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_ifid       <= w_ifid_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_skid       <= w_skid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign if_id_instr = r_ifid.instr;
  assign if_id_pc2   = r_ifid.pc2;
  assign if_id_valid = r_ifid_valid;
  assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential flow, disp jump, execute redirect
// during a wait, stall/skid, HALT and restart, redirect priority and PC wrap.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        jump_disp_en;
  logic        ex_redirect;
  logic [15:0] ex_target;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc2;
  logic        if_id_valid;
  logic        halted;

  int n_vec;
  int n_err;

  // Memory model state
  logic [15:0] mem [256];
  int          lat;
  int          wcnt;
  logic        drv_rdy;
  logic        req_seen;
  logic        jde_en;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdy     (imem_rdy),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .jump_disp_en (jump_disp_en),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .if_id_instr  (if_id_instr),
    .if_id_pc2    (if_id_pc2),
    .if_id_valid  (if_id_valid),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode model: J opcode 00100 in IF/ID raises jump_disp_en when enabled
  assign jump_disp_en = jde_en && (if_id_instr[15:11] == 5'b00100);

  // Memory: responds 'lat' cycles after a request appears; decided at negedge
  always @(negedge clk) begin
    if (!rst_n) begin
      wcnt     = 0;
      drv_rdy  = 1'b0;
      req_seen = 1'b0;
    end else begin
      if (drv_rdy) wcnt = 0;
      else if (req_seen) wcnt = wcnt + 1;
      req_seen = imem_req;
      drv_rdy  = imem_req && (wcnt >= lat);
    end
    imem_rdy   = drv_rdy;
    imem_rdata = drv_rdy ? mem[imem_addr[8:1]] : 16'hDEAD;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h4000 + 16'(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; ex_redirect = 1'b0; ex_target = 16'h0; jde_en = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b required %b", imem_req, 1'b0); end
    n_vec++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_addr: got %h required %h", imem_addr, 16'h0000); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b required %b", if_id_valid, 1'b0); end
    n_vec++; if (if_id_instr !== 16'h0000) begin n_err++; $display("FAIL rst_instr: got %h required %h", if_id_instr, 16'h0000); end
    n_vec++; if (if_id_pc2 !== 16'h0000) begin n_err++; $display("FAIL rst_pc2: got %h required %h", if_id_pc2, 16'h0000); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b required %b", halted, 1'b0); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rel_req: got %b required %b", imem_req, 1'b1); end
  endtask

  task automatic test_sequential();
    init_mem(); lat = 0;
    do_reset();
    @(negedge clk);
    n_vec++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL seq_addr0: got %h required %h", imem_addr, 16'h0000); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_vec++; if (imem_addr !== 16'(2*k)) begin n_err++; $display("FAIL seq_addr: got %h required %h", imem_addr, 16'(2*k)); end
      n_vec++; if (if_id_pc2 !== 16'(2*k)) begin n_err++; $display("FAIL seq_pc2: got %h required %h", if_id_pc2, 16'(2*k)); end
      n_vec++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid: got %b required %b", if_id_valid, 1'b1); end
      n_vec++; if (if_id_instr !== 16'h4000 + 16'(k-1)) begin n_err++; $display("FAIL seq_instr: got %h required %h", if_id_instr, 16'h4000 + 16'(k-1)); end
    end
  endtask

  task automatic test_jump_disp();
    init_mem(); mem[8] = 16'h27FE; lat = 0;
    do_reset();
    jde_en = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++; if (if_id_instr !== 16'h27FE) begin n_err++; $display("FAIL j_instr: got %h required %h", if_id_instr, 16'h27FE); end
    n_vec++; if (if_id_pc2 !== 16'h0012) begin n_err++; $display("FAIL j_pc2: got %h required %h", if_id_pc2, 16'h0012); end
    n_vec++; if (imem_addr !== 16'h0012) begin n_err++; $display("FAIL j_addr_seq: got %h required %h", imem_addr, 16'h0012); end
    @(negedge clk);
    n_vec++; if (imem_addr !== 16'h0010) begin n_err++; $display("FAIL j_addr_tgt: got %h required %h", imem_addr, 16'h0010); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL j_bubble: got %b required %b", if_id_valid, 1'b0); end
    @(negedge clk);
    n_vec++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL j_refetch_valid: got %b required %b", if_id_valid, 1'b1); end
    n_vec++; if (if_id_pc2 !== 16'h0012) begin n_err++; $display("FAIL j_refetch_pc2: got %h required %h", if_id_pc2, 16'h0012); end
    jde_en = 1'b0;
    @(negedge clk);
    n_vec++; if (if_id_pc2 !== 16'h0014) begin n_err++; $display("FAIL j_after_pc2: got %h required %h", if_id_pc2, 16'h0014); end
    n_vec++; if (if_id_instr !== 16'h4009) begin n_err++; $display("FAIL j_after_instr: got %h required %h", if_id_instr, 16'h4009); end
  endtask

  task automatic test_ex_redirect_wait();
    init_mem(); lat = 2;
    do_reset();
    @(negedge clk);
    ex_redirect = 1'b1; ex_target = 16'h0100;
    @(negedge clk);
    ex_redirect = 1'b0;
    n_vec++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL exw_hold1: got %h required %h", imem_addr, 16'h0000); end
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL exw_req1: got %b required %b", imem_req, 1'b1); end
    @(negedge clk);
    n_vec++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL exw_hold2: got %h required %h", imem_addr, 16'h0000); end
    @(negedge clk);
    n_vec++; if (imem_addr !== 16'h0100) begin n_err++; $display("FAIL exw_tgt: got %h required %h", imem_addr, 16'h0100); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL exw_drop: got %b required %b", if_id_valid, 1'b0); end
    repeat (2) @(negedge clk);
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL exw_wait: got %b required %b", if_id_valid, 1'b0); end
    @(negedge clk);
    n_vec++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL exw_valid: got %b required %b", if_id_valid, 1'b1); end
    n_vec++; if (if_id_pc2 !== 16'h0102) begin n_err++; $display("FAIL exw_pc2: got %h required %h", if_id_pc2, 16'h0102); end
    n_vec++; if (if_id_instr !== 16'h4080) begin n_err++; $display("FAIL exw_instr: got %h required %h", if_id_instr, 16'h4080); end
  endtask

  task automatic test_drain_overwrite();
    init_mem(); lat = 3;
    do_reset();
    @(negedge clk);
    ex_redirect = 1'b1; ex_target = 16'h0100;
    @(negedge clk);
    ex_target = 16'h0200;
    @(negedge clk);
    ex_redirect = 1'b0;
    n_vec++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL drn_hold: got %h required %h", imem_addr, 16'h0000); end
    repeat (2) @(negedge clk);
    n_vec++; if (imem_addr !== 16'h0200) begin n_err++; $display("FAIL drn_tgt: got %h required %h", imem_addr, 16'h0200); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL drn_valid: got %b required %b", if_id_valid, 1'b0); end
  endtask

  task automatic test_stall();
    init_mem(); lat = 0;
    do_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (if_id_pc2 !== 16'h0004) begin n_err++; $display("FAIL stl_pre_pc2: got %h required %h", if_id_pc2, 16'h0004); end
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stl_req: got %b required %b", imem_req, 1'b0); end
      n_vec++; if (if_id_pc2 !== 16'h0004) begin n_err++; $display("FAIL stl_hold_pc2: got %h required %h", if_id_pc2, 16'h0004); end
      n_vec++; if (if_id_instr !== 16'h4001) begin n_err++; $display("FAIL stl_hold_instr: got %h required %h", if_id_instr, 16'h4001); end
    end
    stall = 1'b0;
    @(negedge clk);
    n_vec++; if (if_id_pc2 !== 16'h0006) begin n_err++; $display("FAIL stl_skid_pc2: got %h required %h", if_id_pc2, 16'h0006); end
    n_vec++; if (if_id_instr !== 16'h4002) begin n_err++; $display("FAIL stl_skid_instr: got %h required %h", if_id_instr, 16'h4002); end
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stl_req_back: got %b required %b", imem_req, 1'b1); end
    n_vec++; if (imem_addr !== 16'h0006) begin n_err++; $display("FAIL stl_addr: got %h required %h", imem_addr, 16'h0006); end
    @(negedge clk);
    n_vec++; if (if_id_pc2 !== 16'h0008) begin n_err++; $display("FAIL stl_next_pc2: got %h required %h", if_id_pc2, 16'h0008); end
    n_vec++; if (if_id_instr !== 16'h4003) begin n_err++; $display("FAIL stl_next_instr: got %h required %h", if_id_instr, 16'h4003); end
  endtask

  task automatic test_halt();
    init_mem(); mem[3] = 16'h0000; lat = 0;
    do_reset();
    repeat (5) @(negedge clk);
    n_vec++; if (if_id_instr !== 16'h0000) begin n_err++; $display("FAIL hlt_instr: got %h required %h", if_id_instr, 16'h0000); end
    n_vec++; if (if_id_pc2 !== 16'h0008) begin n_err++; $display("FAIL hlt_pc2: got %h required %h", if_id_pc2, 16'h0008); end
    n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL hlt_halted: got %b required %b", halted, 1'b1); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL hlt_req: got %b required %b", imem_req, 1'b0); end
    @(negedge clk);
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL hlt_bubble: got %b required %b", if_id_valid, 1'b0); end
    @(negedge clk);
    n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL hlt_stay: got %b required %b", halted, 1'b1); end
    ex_redirect = 1'b1; ex_target = 16'h0020;
    @(negedge clk);
    ex_redirect = 1'b0;
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL hlt_resume: got %b required %b", halted, 1'b0); end
    n_vec++; if (imem_addr !== 16'h0020) begin n_err++; $display("FAIL hlt_addr: got %h required %h", imem_addr, 16'h0020); end
    n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL hlt_req_back: got %b required %b", imem_req, 1'b1); end
    @(negedge clk);
    n_vec++; if (if_id_pc2 !== 16'h0022) begin n_err++; $display("FAIL hlt_pc2_back: got %h required %h", if_id_pc2, 16'h0022); end
  endtask

  task automatic test_priority_wrap();
    init_mem(); mem[8] = 16'h27FE; lat = 0;
    do_reset();
    jde_en = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++; if (if_id_instr !== 16'h27FE) begin n_err++; $display("FAIL pri_instr: got %h required %h", if_id_instr, 16'h27FE); end
    ex_redirect = 1'b1; ex_target = 16'h0040;
    @(negedge clk);
    ex_redirect = 1'b0; jde_en = 1'b0;
    n_vec++; if (imem_addr !== 16'h0040) begin n_err++; $display("FAIL pri_addr: got %h required %h", imem_addr, 16'h0040); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL pri_flush: got %b required %b", if_id_valid, 1'b0); end
    @(negedge clk);
    n_vec++; if (if_id_pc2 !== 16'h0042) begin n_err++; $display("FAIL pri_pc2: got %h required %h", if_id_pc2, 16'h0042); end

    init_mem(); mem[8'hFE] = 16'h2004;
    do_reset();
    @(negedge clk);
    ex_redirect = 1'b1; ex_target = 16'hFFFC;
    @(negedge clk);
    ex_redirect = 1'b0; jde_en = 1'b1;
    n_vec++; if (imem_addr !== 16'hFFFC) begin n_err++; $display("FAIL wrp_addr0: got %h required %h", imem_addr, 16'hFFFC); end
    @(negedge clk);
    n_vec++; if (if_id_pc2 !== 16'hFFFE) begin n_err++; $display("FAIL wrp_pc2: got %h required %h", if_id_pc2, 16'hFFFE); end
    @(negedge clk);
    jde_en = 1'b0;
    n_vec++; if (imem_addr !== 16'h0002) begin n_err++; $display("FAIL wrp_tgt: got %h required %h", imem_addr, 16'h0002); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL wrp_bubble: got %b required %b", if_id_valid, 1'b0); end
    @(negedge clk);
    n_vec++; if (if_id_pc2 !== 16'h0004) begin n_err++; $display("FAIL wrp_next_pc2: got %h required %h", if_id_pc2, 16'h0004); end
    n_vec++; if (if_id_instr !== 16'h4001) begin n_err++; $display("FAIL wrp_next_instr: got %h required %h", if_id_instr, 16'h4001); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; stall = 1'b0; ex_redirect = 1'b0; ex_target = 16'h0;
    jde_en = 1'b0; lat = 0;
    init_mem();
    test_reset();
    test_sequential();
    test_jump_disp();
    test_ex_redirect_wait();
    test_drain_overwrite();
    test_stall();
    test_halt();
    test_priority_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage with the IF/ID pipeline register for the 16-bit WISC core. It owns the PC and issues requests to instruction memory over a req/rdy handshake. It applies redirects from execute (branches, register jumps) and from decode (J/JAL displacement jumps, flagged by the decode opcode control), and buffers one instruction while decode is stalled. It stops fetching after a HALT instruction.

## Interface
- No parameters; data/address width fixed at 16, instruction opcode = instr[15:11], HALT opcode = 5'b00000.
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  16  fetch address (= PC of request)
- imem_rdy  in  1  response valid this cycle; completes current request
- imem_rdata  in  16  instruction word, valid with imem_rdy
- stall  in  1  decode stall; hold IF/ID
- jump_disp_en  in  1  decode says if_id_instr is J/JAL disp (combinational from if_id_instr[15:11])
- ex_redirect  in  1  execute redirect (taken branch, JR/JALR)
- ex_target  in  16  execute redirect target
- if_id_instr  out  16  instruction to decode
- if_id_pc2  out  16  PC+2 of that instruction
- if_id_valid  out  1  IF/ID holds a live instruction
- halted  out  1  fetch stopped on HALT

## Operation
- State regs: pc[15:0], state {FETCH, DRAIN, HALT}, skid (instr, pc2, valid), pend_pc[15:0].
- FETCH: imem_req=1 when skid empty, imem_addr=pc; address held stable until imem_rdy (one outstanding request).
- Accept (FETCH, imem_rdy, no redirect): pc <= pc+2 (mod 2^16). If stall=0 and skid empty: IF/ID <= {rdata, pc+2}, valid=1. Else skid <= {rdata, pc+2}.
- stall=0 with skid valid: IF/ID <= skid, skid cleared; a same-cycle arrival goes to skid.
- stall=1: IF/ID unchanged; jump_disp_en ignored.
- Decode redirect: if_id_valid & jump_disp_en & !stall & !ex_redirect → target = if_id_pc2 + sext(if_id_instr[10:0]), 16-bit wrap.
- Redirect priority: ex_redirect > decode redirect > sequential. Any redirect clears if_id_valid and skid valid and ignores stall.
- Redirect with no request outstanding, or coincident with imem_rdy: data discarded; pc <= target; state FETCH.
- Redirect while request outstanding and imem_rdy=0: pend_pc <= target; → DRAIN. In DRAIN imem_req=1 and addr is held. Next imem_rdy: data discarded, pc <= pend_pc, → FETCH. A later redirect in DRAIN overwrites pend_pc.
- HALT: accepted word with opcode 00000 is delivered normally (IF/ID or skid), pc advances, → HALT. In HALT: imem_req=0, halted=1. ex_redirect in HALT: flush, pc <= ex_target, → FETCH, halted=0. Decode redirect in HALT behaves the same.
- Reset: pc=0x0000, state FETCH, if_id_instr=0, if_id_pc2=0, if_id_valid=0, skid valid=0, pend_pc=0, halted=0, imem_req=0 during reset (1 on first cycle after release).

## Timing
- Zero-wait memory (rdy with req): one instruction per cycle. Word fetched at PC P appears in IF/ID the next cycle with pc2=P+2.
- Redirect to first request at target: next cycle if no outstanding request, else one cycle after the draining imem_rdy.
- Decode-redirect penalty: one bubble (the word fetched alongside is discarded).
- Skid drains the first cycle stall=0; no requests issue while skid is valid.
- Reset release mid-request: the outstanding transaction is abandoned; memory must tolerate this.

## Test plan
- Reset then zero-wait memory with NOPs: imem_addr 0,2,4,…; if_id_pc2 2,4,6,… one cycle later; valid stays 1.
- J disp at 0x0010, disp=0x7FE (−2): target 0x0010; next imem_addr=0x0010. Word at 0x0012 is flushed; one bubble on if_id_valid.
- Memory 3-cycle latency; ex_redirect=1, ex_target=0x0100 in wait cycle 1: imem_addr held until rdy, data dropped, then next request at 0x0100.
- stall=1 for 3 cycles with zero-wait memory: IF/ID held, one word in skid, imem_req=0. On release, IF/ID takes the skid word, then sequential flow resumes with no loss or duplication.
- HALT at 0x0006: delivered to IF/ID, halted=1, imem_req=0. Later ex_redirect to 0x0020 resumes fetch at 0x0020 with halted=0.
- ex_redirect and jump_disp_en in same cycle: ex_target wins. Disp jump from pc2=0xFFFE with disp=+4: target wraps to 0x0002.
